// File: rtl/acc_cpu_if.sv
// Host-side bus of the accumulator CPU: program-load port plus the in/out streams.
// Handshake rule: a transfer happens on the rising edge where valid && ready are both 1.
interface acc_cpu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                prog_we;
  logic [ADDR_W-1:0]   prog_addr;
  logic [ADDR_W+3:0]   prog_data;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output prog_we, prog_addr, prog_data, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/acc_cpu.sv
// Multi-cycle accumulator CPU (HALT/FETCH/EXEC) with loadable program memory and stream IO.
// Optional feature: define ACC_CPU_SHIFT_EN to make opcode E a left shift (otherwise NOP).
module acc_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  acc_cpu_if.slave          bus,
  output logic              hlt,
  output logic              z_flag,
  output logic              s_flag,
  output logic              c_flag,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state_dbg
);
  localparam int IW    = 4 + ADDR_W;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC, OP_OUT = 4'hD, OP_SHL = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_HALT = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [IW-1:0]       ir, ir_n;
  logic [DATA_W-1:0]   acc, acc_n;
  logic                z_n, s_n, c_n, flag_upd;
  logic                imem_we, dmem_we;
  logic [DATA_W:0]     sum;

  logic [IW-1:0]       imem [DEPTH];
  logic [DATA_W-1:0]   dmem [DEPTH];

  logic [3:0]          op;
  logic [ADDR_W-1:0]   a;
  logic [DATA_W-1:0]   dval;

  assign op   = ir[IW-1 -: 4];
  assign a    = ir[ADDR_W-1:0];
  assign dval = dmem[a];

  assign hlt           = (state == S_HALT);
  assign state_dbg     = state;
  assign bus.out_data  = acc;
  assign bus.in_ready  = (state == S_EXEC) && (op == OP_IN);
  assign bus.out_valid = (state == S_EXEC) && (op == OP_OUT);

  // Gated by rst as well so nothing lands in memory while reset is held.
  assign imem_we = (state == S_HALT) && bus.prog_we && !rst;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    acc_n    = acc;
    z_n      = z_flag;
    s_n      = s_flag;
    c_n      = c_flag;
    flag_upd = 1'b0;
    dmem_we  = 1'b0;
    sum      = '0;
    unique case (state)
      S_HALT: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_n    = imem[pc];
        pc_n    = pc + ADDR_W'(1);
        state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_FETCH;
        case (op)
          OP_LDI: begin acc_n = DATA_W'(a); flag_upd = 1'b1; end
          OP_LDA: begin acc_n = dval;       flag_upd = 1'b1; end
          OP_STA: dmem_we = 1'b1;
          OP_ADD: begin
            sum      = {1'b0, acc} + {1'b0, dval};
            acc_n    = sum[DATA_W-1:0];
            c_n      = sum[DATA_W];
            flag_upd = 1'b1;
          end
          OP_SUB: begin
            acc_n    = acc - dval;
            c_n      = (acc < dval);
            flag_upd = 1'b1;
          end
          OP_AND: begin acc_n = acc & dval; flag_upd = 1'b1; end
          OP_OR:  begin acc_n = acc | dval; flag_upd = 1'b1; end
          OP_XOR: begin acc_n = acc ^ dval; flag_upd = 1'b1; end
          OP_JMP: pc_n = a;
          OP_JZ:  if (z_flag) pc_n = a;
          OP_JC:  if (c_flag) pc_n = a;
          OP_IN: begin
            if (bus.in_valid) begin
              acc_n    = bus.in_data;
              flag_upd = 1'b1;
            end else begin
              state_n = S_EXEC;
            end
          end
          OP_OUT: if (!bus.out_ready) state_n = S_EXEC;
          OP_SHL: begin
`ifdef ACC_CPU_SHIFT_EN
            c_n      = acc[DATA_W-1];
            acc_n    = {acc[DATA_W-2:0], 1'b0};
            flag_upd = 1'b1;
`endif
          end
          OP_HLT: state_n = S_HALT;
          default: ;
        endcase
      end
      default: state_n = S_HALT;
    endcase
    if (flag_upd) begin
      z_n = (acc_n == '0);
      s_n = acc_n[DATA_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_HALT;
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      z_flag <= 1'b0;
      s_flag <= 1'b0;
      c_flag <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir     <= ir_n;
      acc    <= acc_n;
      z_flag <= z_n;
      s_flag <= s_n;
      c_flag <= c_n;
    end
  end

  // Memories carry no reset; dmem_we is only raised in EXEC, which reset leaves at once.
  always_ff @(posedge clk) begin
    if (imem_we) imem[bus.prog_addr] <= bus.prog_data;
    if (dmem_we) dmem[a] <= acc;
  end
endmodule

// File: tb/tb_acc_cpu.sv
// Directed bench for acc_cpu: OUT beats go through an expected queue checked by a monitor,
// register-visible results are checked directly after each program halts.
module tb_acc_cpu;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int W      = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              hlt, z_flag, s_flag, c_flag;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  acc_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  acc_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .hlt(hlt), .z_flag(z_flag), .s_flag(s_flag), .c_flag(c_flag),
    .pc(pc), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Monitor: each OUT beat ({z,c,data}) is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: unexpected beat data=%h z=%0b c=%0b, required none",
                 bus.out_data, z_flag, c_flag);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({z_flag, c_flag, bus.out_data} !== e) begin
          errors++;
          $display("FAIL out_beat: got z,c,data=%h required %h",
                   {z_flag, c_flag, bus.out_data}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [ADDR_W-1:0] addr, input logic [ADDR_W+3:0] word);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = word;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_hlt(input string name);
    int n = 0;
    while (!hlt && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hlt) chk({name, "_halt_timeout"}, 32'(hlt), 32'd1);
  endtask

  task automatic wait_in_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk({name, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk({name, "_out_valid_timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic send_in(input string name, input logic [DATA_W-1:0] d);
    wait_in_ready(name);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_hlt", 32'(hlt), 32'd1);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_flags", {29'd0, z_flag, s_flag, c_flag}, 32'd0);
    chk("rst_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);

    // Arithmetic and OUT: 5 + 3
    load(0, 8'h15); load(1, 8'h30); load(2, 8'h13);
    load(3, 8'h40); load(4, 8'hD0); load(5, 8'hF0);
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h08});
    pulse_start();
    chk("arith_running", 32'(hlt), 32'd0);
    wait_hlt("arith");
    chk("arith_pc", 32'(pc), 32'd6);
    chk("arith_beats", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Carry: 0xF0 + 0xF0
    do_reset();
    load(0, 8'hC0); load(1, 8'h30); load(2, 8'h40); load(3, 8'hF0);
    pulse_start();
    send_in("carry", 8'hF0);
    wait_hlt("carry");
    chk("carry_acc", 32'(bus.out_data), 32'hE0);
    chk("carry_cs", {30'd0, c_flag, s_flag}, 32'd3);

    // Borrow: 0 - 1
    do_reset();
    load(0, 8'h11); load(1, 8'h31); load(2, 8'h10); load(3, 8'h51); load(4, 8'hF0);
    pulse_start();
    wait_hlt("borrow");
    chk("borrow_acc", 32'(bus.out_data), 32'hFF);
    chk("borrow_zsc", {29'd0, z_flag, s_flag, c_flag}, 32'b011);
    chk("borrow_pc", 32'(pc), 32'd5);

    // Taken branch at the top of memory
    do_reset();
    load(0, 8'h9E); load(14, 8'h10); load(15, 8'hA3); load(3, 8'hF0);
    pulse_start();
    wait_hlt("jz");
    chk("jz_pc", 32'(pc), 32'd4);
    chk("jz_z", 32'(z_flag), 32'd1);

    // pc wrap from 15 to 0, observed by re-entering the IN at address 0
    do_reset();
    load(0, 8'hC0); load(1, 8'hA5); load(2, 8'h9E); load(5, 8'hF0);
    load(14, 8'h00); load(15, 8'h00);
    pulse_start();
    send_in("wrap1", 8'h07);
    wait_in_ready("wrap2");
    chk("wrap_pc", 32'(pc), 32'd1);
    send_in("wrap2", 8'h00);
    wait_hlt("wrap");
    chk("wrap_end_pc", 32'(pc), 32'd6);

    // IN and OUT stalls
    do_reset();
    load(0, 8'hC0); load(1, 8'hD0); load(2, 8'hF0);
    pulse_start();
    wait_in_ready("stall");
    for (int i = 0; i < 5; i++) begin
      chk("in_stall", {27'd0, bus.in_ready, pc}, {27'd0, 1'b1, 4'd1});
      @(negedge clk);
    end
    send_in("stall", 8'h2A);
    wait_out_valid("stall");
    for (int i = 0; i < 4; i++) begin
      chk("out_stall", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h2A});
      @(negedge clk);
    end
    exp_q.push_back({1'b0, 1'b0, 8'h2A});
    bus.out_ready = 1'b1;
    wait_hlt("stall");
    chk("stall_pc", 32'(pc), 32'd3);
    chk("stall_beats", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // imem write while running is dropped: OUT at address 1 must survive
    do_reset();
    load(0, 8'hC0); load(1, 8'hD0); load(2, 8'hF0);
    pulse_start();
    wait_in_ready("guard");
    load(1, 8'hF0);
    exp_q.push_back({1'b0, 1'b0, 8'h33});
    bus.out_ready = 1'b1;
    send_in("guard", 8'h33);
    wait_hlt("guard");
    chk("guard_pc", 32'(pc), 32'd3);
    chk("guard_beats", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset during an OUT stall
    do_reset();
    load(0, 8'h19); load(1, 8'hD0); load(2, 8'hF0);
    pulse_start();
    wait_out_valid("rst_out");
    chk("rst_out_acc", 32'(bus.out_data), 32'h09);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_hlt", 32'(hlt), 32'd1);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SHL on 0x81
    do_reset();
    load(0, 8'hC0); load(1, 8'hE0); load(2, 8'hF0);
    pulse_start();
    send_in("shl", 8'h81);
    wait_hlt("shl");
`ifdef ACC_CPU_SHIFT_EN
    chk("shl_acc", 32'(bus.out_data), 32'h02);
    chk("shl_zsc", {29'd0, z_flag, s_flag, c_flag}, 32'b001);
`else
    chk("shl_acc", 32'(bus.out_data), 32'h81);
    chk("shl_zsc", {29'd0, z_flag, s_flag, c_flag}, 32'b010);
`endif
    chk("shl_pc", 32'(pc), 32'd3);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
